// File: rtl/spike_window_decoder.sv
// Windowed spike-train decoder: per-window spike rate, minimum ISI, peak membrane
// potential and burst detection, delivered through a valid/ack result register.
module spike_window_decoder #(
    parameter int unsigned WIN_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                spike_in,
    input  logic [6:0]          v_mem_in,
    input  logic [WIN_BITS-1:0] window_cycles,
    input  logic [3:0]          burst_isi,
    input  logic                out_ack,
    output logic                out_valid,
    output logic [WIN_BITS-1:0] rate_out,
    output logic [WIN_BITS-1:0] isi_min_out,
    output logic [6:0]          peak_vmem_out,
    output logic                burst_flag,
    output logic                overrun
);

    localparam logic [WIN_BITS-1:0] Ones = '1;
    localparam logic [WIN_BITS-1:0] One  = WIN_BITS'(1);

    typedef enum logic {StIdle, StAccum} state_t;

    state_t              state;
    logic [WIN_BITS-1:0] shadow_len;
    logic [WIN_BITS-1:0] cyc_cnt;
    logic [WIN_BITS-1:0] spike_cnt;
    logic [WIN_BITS-1:0] isi_cnt;
    logic [WIN_BITS-1:0] isi_min;
    logic [6:0]          peak;
    logic                prev_spike;
    logic                seen_spike;

    logic                spike_evt;
    logic                win_end;
    logic [WIN_BITS-1:0] last_cyc;
    logic [WIN_BITS-1:0] cnt_nxt;
    logic [WIN_BITS-1:0] min_nxt;
    logic [6:0]          peak_nxt;
    logic [WIN_BITS-1:0] isi_nxt;
    logic                burst_nxt;

    always_comb begin
        spike_evt = spike_in & ~prev_spike;
        // shadow_len of 0 wraps to all-ones, giving a 2^WIN_BITS-cycle window
        last_cyc  = shadow_len - One;
        win_end   = (cyc_cnt == last_cyc);
        cnt_nxt   = (spike_evt && spike_cnt != Ones) ? spike_cnt + One : spike_cnt;
        min_nxt   = (spike_evt && seen_spike && isi_cnt < isi_min) ? isi_cnt : isi_min;
        peak_nxt  = (v_mem_in > peak) ? v_mem_in : peak;
        isi_nxt   = spike_evt ? One : ((isi_cnt == Ones) ? isi_cnt : isi_cnt + One);
        burst_nxt = ((WIN_BITS + 4)'(min_nxt) < (WIN_BITS + 4)'(burst_isi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            shadow_len    <= '0;
            cyc_cnt       <= '0;
            spike_cnt     <= '0;
            isi_cnt       <= '0;
            isi_min       <= Ones;
            peak          <= '0;
            prev_spike    <= 1'b0;
            seen_spike    <= 1'b0;
            out_valid     <= 1'b0;
            rate_out      <= '0;
            isi_min_out   <= Ones;
            peak_vmem_out <= '0;
            burst_flag    <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            prev_spike <= spike_in;
            if (out_ack && out_valid) begin
                out_valid <= 1'b0;
            end
            unique case (state)
                StIdle: begin
                    cyc_cnt    <= '0;
                    spike_cnt  <= '0;
                    isi_cnt    <= '0;
                    isi_min    <= Ones;
                    peak       <= '0;
                    seen_spike <= 1'b0;
                    if (enable) begin
                        state      <= StAccum;
                        shadow_len <= window_cycles;
                    end
                end
                StAccum: begin
                    if (!enable) begin
                        state      <= StIdle;
                        cyc_cnt    <= '0;
                        spike_cnt  <= '0;
                        isi_cnt    <= '0;
                        isi_min    <= Ones;
                        peak       <= '0;
                        seen_spike <= 1'b0;
                    end else begin
                        isi_cnt <= isi_nxt;
                        if (spike_evt) begin
                            seen_spike <= 1'b1;
                        end
                        if (win_end) begin
                            // Later assignment overrides the ack clear above
                            out_valid     <= 1'b1;
                            rate_out      <= cnt_nxt;
                            isi_min_out   <= min_nxt;
                            peak_vmem_out <= peak_nxt;
                            burst_flag    <= burst_nxt;
                            if (out_valid && !out_ack) begin
                                overrun <= 1'b1;
                            end
                            spike_cnt  <= '0;
                            isi_min    <= Ones;
                            peak       <= '0;
                            cyc_cnt    <= '0;
                            shadow_len <= window_cycles;
                        end else begin
                            spike_cnt <= cnt_nxt;
                            isi_min   <= min_nxt;
                            peak      <= peak_nxt;
                            cyc_cnt   <= cyc_cnt + One;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_window_decoder.sv
// Directed bench for spike_window_decoder; expected values are hand-computed.
module tb_spike_window_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       spike_in = 1'b0;
    logic [6:0] v_mem_in = 7'd0;
    logic [7:0] window_cycles = 8'd10;
    logic [3:0] burst_isi = 4'd0;
    logic       out_ack = 1'b0;
    logic       out_valid;
    logic [7:0] rate_out;
    logic [7:0] isi_min_out;
    logic [6:0] peak_vmem_out;
    logic       burst_flag;
    logic       overrun;

    int total = 0;
    int bad = 0;

    spike_window_decoder #(.WIN_BITS(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .spike_in      (spike_in),
        .v_mem_in      (v_mem_in),
        .window_cycles (window_cycles),
        .burst_isi     (burst_isi),
        .out_ack       (out_ack),
        .out_valid     (out_valid),
        .rate_out      (rate_out),
        .isi_min_out   (isi_min_out),
        .peak_vmem_out (peak_vmem_out),
        .burst_flag    (burst_flag),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        enable   = 1'b0;
        spike_in = 1'b0;
        out_ack  = 1'b1;
        step();
        step();
        out_ack  = 1'b0;
    endtask

    task automatic start(input logic [7:0] len);
        window_cycles = len;
        enable        = 1'b1;
        step();
    endtask

    // One window of n cycles; spike_in follows mask, v_mem_in is 5 except pk_val at pk_cyc
    task automatic run_window(input int n, input logic [31:0] mask, input int pk_cyc,
                              input logic [6:0] pk_val);
        for (int c = 0; c < n; c++) begin
            spike_in = mask[c];
            v_mem_in = (c == pk_cyc) ? pk_val : 7'd5;
            step();
        end
        spike_in = 1'b0;
        v_mem_in = 7'd5;
    endtask

    task automatic test_reset();
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %0b want 0", out_valid); end
        total++; if (rate_out !== 8'd0) begin bad++; $display("FAIL rst_rate got %0d want 0", rate_out); end
        total++; if (isi_min_out !== 8'hff) begin bad++; $display("FAIL rst_isi got %0d want 255", isi_min_out); end
        total++; if (peak_vmem_out !== 7'd0) begin bad++; $display("FAIL rst_peak got %0d want 0", peak_vmem_out); end
        total++; if (burst_flag !== 1'b0) begin bad++; $display("FAIL rst_burst got %0b want 0", burst_flag); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got %0b want 0", overrun); end
        rst_n = 1'b1;
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ack_ignored got %0b want 0", out_valid); end
    endtask

    task automatic test_basic();
        go_idle();
        burst_isi = 4'd0;
        start(8'd10);
        run_window(10, 32'h0000_0224, 9, 7'd77);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got %0b want 1", out_valid); end
        total++; if (rate_out !== 8'd3) begin bad++; $display("FAIL basic_rate got %0d want 3", rate_out); end
        total++; if (isi_min_out !== 8'd3) begin bad++; $display("FAIL basic_isi got %0d want 3", isi_min_out); end
        total++; if (peak_vmem_out !== 7'd77) begin bad++; $display("FAIL basic_peak got %0d want 77", peak_vmem_out); end
        total++; if (burst_flag !== 1'b0) begin bad++; $display("FAIL basic_burst got %0b want 0", burst_flag); end
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_ack got %0b want 0", out_valid); end
    endtask

    task automatic test_burst();
        go_idle();
        burst_isi = 4'd4;
        start(8'd10);
        run_window(10, 32'h0000_000a, 0, 7'd5);
        total++; if (rate_out !== 8'd2) begin bad++; $display("FAIL burst_rate got %0d want 2", rate_out); end
        total++; if (isi_min_out !== 8'd2) begin bad++; $display("FAIL burst_isi got %0d want 2", isi_min_out); end
        total++; if (burst_flag !== 1'b1) begin bad++; $display("FAIL burst_flag4 got %0b want 1", burst_flag); end
        go_idle();
        burst_isi = 4'd2;
        start(8'd10);
        run_window(10, 32'h0000_000a, 0, 7'd5);
        total++; if (isi_min_out !== 8'd2) begin bad++; $display("FAIL burst2_isi got %0d want 2", isi_min_out); end
        total++; if (burst_flag !== 1'b0) begin bad++; $display("FAIL burst_flag2 got %0b want 0", burst_flag); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat;
        logic [3:0] exp_rate;
        go_idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        pat      = 4'b1101;
        exp_rate = 4'b0101;
        start(8'd1);
        out_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            spike_in = pat[c];
            step();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got %0b want 1", c, out_valid); end
            total++; if (rate_out !== {7'd0, exp_rate[c]}) begin bad++; $display("FAIL b2b_rate[%0d] got %0d want %0d", c, rate_out, exp_rate[c]); end
            total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun[%0d] got %0b want 0", c, overrun); end
        end
        out_ack = 1'b0;
    endtask

    task automatic test_long_window();
        go_idle();
        start(8'd0);
        for (int c = 0; c < 256; c++) begin
            spike_in = (c >= 3 && c < 8);
            v_mem_in = (c == 100) ? 7'd99 : 7'd5;
            step();
            if (c == 254) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL long_early got %0b want 0", out_valid); end
            end
        end
        spike_in = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL long_valid got %0b want 1", out_valid); end
        total++; if (rate_out !== 8'd1) begin bad++; $display("FAIL long_rate got %0d want 1", rate_out); end
        total++; if (peak_vmem_out !== 7'd99) begin bad++; $display("FAIL long_peak got %0d want 99", peak_vmem_out); end
        total++; if (isi_min_out !== 8'hff) begin bad++; $display("FAIL long_isi got %0d want 255", isi_min_out); end
    endtask

    task automatic test_overrun();
        go_idle();
        start(8'd4);
        run_window(4, 32'h0000_0001, 0, 7'd5);
        run_window(4, 32'h0000_0005, 0, 7'd5);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got %0b want 1", out_valid); end
        total++; if (rate_out !== 8'd2) begin bad++; $display("FAIL ovr_rate got %0d want 2", rate_out); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got %0b want 1", overrun); end
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovr_ack got %0b want 0", out_valid); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got %0b want 1", overrun); end
    endtask

    task automatic test_abort();
        go_idle();
        start(8'd10);
        run_window(4, 32'h0000_0004, 0, 7'd5);
        enable = 1'b0;
        for (int c = 0; c < 12; c++) step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_en_valid got %0b want 0", out_valid); end
        total++; if (rate_out !== 8'd2) begin bad++; $display("FAIL abort_en_hold got %0d want 2", rate_out); end
        start(8'd10);
        run_window(4, 32'h0000_0004, 0, 7'd5);
        rst_n = 1'b0;
        #2;
        total++; if (rate_out !== 8'd0) begin bad++; $display("FAIL abort_rst_rate got %0d want 0", rate_out); end
        total++; if (isi_min_out !== 8'hff) begin bad++; $display("FAIL abort_rst_isi got %0d want 255", isi_min_out); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL abort_rst_overrun got %0b want 0", overrun); end
        total++; if (peak_vmem_out !== 7'd0) begin bad++; $display("FAIL abort_rst_peak got %0d want 0", peak_vmem_out); end
        enable = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_rst_valid got %0b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_burst();
        test_back_to_back();
        test_long_window();
        test_overrun();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spike_window_decoder.md
SPIKE_WINDOW_DECODER -- requirements
Module: spike_window_decoder

Interface
REQ-001 The block SHALL have one parameter: WIN_BITS, default 8, width of the window-length input, cycle counter and result counters.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port `clk`: input, 1 bit, sole clock, rising edge.
REQ-004 Port `rst_n`: input, 1 bit, asynchronous active-low reset.
REQ-005 Port `enable`: input, 1 bit, decoding enable.
REQ-006 Port `spike_in`: input, 1 bit, spike train from the neuron `spike_out`.
REQ-007 Port `v_mem_in`: input, 7 bits, membrane potential from the neuron `v_mem_out`.
REQ-008 Port `window_cycles`: input, WIN_BITS, window length in cycles; 0 means 2^WIN_BITS.
REQ-009 Port `burst_isi`: input, 4 bits, burst-detection inter-spike-interval limit.
REQ-010 Port `out_ack`: input, 1 bit, consumer acknowledge.
REQ-011 Port `out_valid`: output, 1 bit, result available.
REQ-012 Port `rate_out`: output, WIN_BITS, spike count of the last window.
REQ-013 Port `isi_min_out`: output, WIN_BITS, minimum inter-spike interval of the last window.
REQ-014 Port `peak_vmem_out`: output, 7 bits, maximum `v_mem_in` seen during the last window.
REQ-015 Port `burst_flag`: output, 1 bit, burst detected in the last window.
REQ-016 Port `overrun`: output, 1 bit, sticky flag: a result was lost.

Function
REQ-017 The state machine SHALL have two states, IDLE and ACCUM.
REQ-018 IDLE -> ACCUM SHALL occur on the first cycle `enable`=1; that edge loads `window_cycles` into a shadow register and clears all accumulators.
REQ-019 ACCUM -> IDLE SHALL occur on any cycle `enable`=0.
REQ-020 In IDLE the block SHALL clear the cycle counter, accumulators and ISI tracker, hold the output registers, and still honour `out_ack`.
REQ-021 A spike event SHALL be a rising edge of `spike_in`: current sample 1, previous sample 0; the previous-sample register resets to 0.
REQ-022 In ACCUM the block SHALL count cycles 0..N-1, N = shadow length; cycle N-1 is the window-end cycle.
REQ-023 The spike counter SHALL increment per event and saturate at 2^WIN_BITS-1.
REQ-024 The ISI counter SHALL increment every ACCUM cycle, saturate at 2^WIN_BITS-1, reset to 1 on the cycle after an event, and run across window boundaries.
REQ-025 On each event after the first since entering ACCUM, the block SHALL set isi_min = min(isi_min, ISI counter); isi_min restarts at all-ones each window.
REQ-026 The peak register SHALL take max(peak, `v_mem_in`) every ACCUM cycle and restart at 0 each window.
REQ-027 At the window-end edge the block SHALL load the results, including any event or sample on that same cycle, into the output registers.
REQ-028 At that same edge the block SHALL clear the accumulators, reload the shadow length from `window_cycles`, and restart the cycle counter at 0; no cycle is dropped between windows.
REQ-029 `burst_flag` SHALL be loaded as (isi_min < `burst_isi`); `burst_isi`=0 never flags.
REQ-030 `out_valid` SHALL rise at the window-end edge, visible on the first cycle of the next window.
REQ-031 `out_valid` SHALL stay high until sampled with `out_ack`=1, then clear.
REQ-032 `out_ack` while `out_valid`=0 SHALL be ignored.
REQ-033 If window end coincides with `out_ack`=1 and `out_valid`=1, the new result SHALL load, `out_valid` SHALL stay 1, and `overrun` SHALL be unchanged.
REQ-034 If window end occurs with `out_valid`=1 and `out_ack`=0, the new result SHALL overwrite the old one and `overrun` SHALL be set; only reset clears it.
REQ-035 Deasserting `enable` mid-window SHALL discard the partial window without producing output.

Reset
REQ-036 `rst_n`=0 SHALL immediately force IDLE, clear all counters and the previous-spike register, and set `out_valid`, `rate_out`, `peak_vmem_out`, `burst_flag` and `overrun` to 0 and `isi_min_out` to all-ones.
REQ-037 Reset asserted mid-window SHALL discard all state, with no result emitted.
REQ-038 After reset release the block SHALL wait for `enable` per REQ-018.

Verification
REQ-039 `window_cycles`=10; spikes at window cycles 2, 5 and 9 (cycle 9 is the end cycle) -> `rate_out`=3, `isi_min_out`=3, `out_valid` high on next-window cycle 0.
REQ-040 `burst_isi`=4; spikes at cycles 1 and 3 -> `isi_min_out`=2, `burst_flag`=1; repeat with `burst_isi`=2 -> `burst_flag`=0.
REQ-041 Two windows complete with no `out_ack` -> second result visible, `overrun`=1; a later ack clears `out_valid` but not `overrun`.
REQ-042 `out_ack` held high through each window end -> every result loads, `overrun` stays 0.
REQ-043 `spike_in` held at 1 for 5 cycles -> counted once; `window_cycles`=0 -> window is 256 cycles.
REQ-044 Pulse `rst_n` low or drop `enable` at window cycle 4 -> no `out_valid`; reset case outputs at reset values.
